// File: rtl/conv2d_bn_act_stream_param_if.sv
// Bundle of the control, memory-read and packed-output stream signals of the conv engine.
// The master modport is the engine side; slave is the memories/sink side.
interface conv2d_bn_act_stream_param_if;
    logic        start;
    logic        cfg_relu6;
    logic        busy;
    logic        done;
    logic [31:0] fm_addr;
    logic [7:0]  fm_rdata;
    logic [31:0] wt_addr;
    logic [7:0]  wt_rdata;
    logic [15:0] par_addr;
    logic [7:0]  bias_rdata;
    logic [7:0]  scale_rdata;
    logic [7:0]  shift_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;

    modport master (
        input  start, cfg_relu6, fm_rdata, wt_rdata, bias_rdata, scale_rdata, shift_rdata, out_ready,
        output busy, done, fm_addr, wt_addr, par_addr, out_valid, out_addr, out_data
    );

    modport slave (
        output start, cfg_relu6, fm_rdata, wt_rdata, bias_rdata, scale_rdata, shift_rdata, out_ready,
        input  busy, done, fm_addr, wt_addr, par_addr, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/conv2d_bn_act_stream_param.sv
// KxK convolution + bias + batch-norm + clipped activation, one tap per cycle,
// packing OUT_BITS-wide activations MSB-first into 32-bit words on a valid/ready port.
module conv2d_bn_act_stream_param #(
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int NUM_CH    = 3,
    parameter int NUM_FILT  = 32,
    parameter int KSIZE     = 3,
    parameter int STRIDE    = 1,
    parameter int PAD       = 1,
    parameter int OUT_BITS  = 4,
    parameter int ACC_SHIFT = 7,
    parameter int BN_SHIFT  = 7
) (
    input  logic                          clk,
    input  logic                          resetn,
    conv2d_bn_act_stream_param_if.master  bus
);
    localparam int T       = NUM_CH * KSIZE * KSIZE;
    localparam int OUT_W   = (IMG_W + 2 * PAD - KSIZE) / STRIDE + 1;
    localparam int OUT_H   = (IMG_H + 2 * PAD - KSIZE) / STRIDE + 1;
    localparam int PACK    = 32 / OUT_BITS;
    localparam int ACT_MAX = (1 << OUT_BITS) - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_POST, S_PACK, S_WRITE, S_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic [31:0]        r_c, r_i, r_j, r_ox, r_oy, r_slot, r_out_addr, r_word;
    logic [15:0]        r_f;
    logic signed [31:0] r_acc;
    logic [OUT_BITS-1:0] r_act;
    logic               r_relu6, r_plane_end;
    logic               r_acc_en, r_oob_d, r_first_d;

    logic w_last_tap, w_last_pix, w_last_filt, w_hs, w_in_range;
    logic signed [31:0] w_iy, w_ix;
    logic [31:0]        w_fm_lin, w_wt_lin, w_word_next;

    assign w_last_tap  = (r_c == NUM_CH - 1) && (r_i == KSIZE - 1) && (r_j == KSIZE - 1);
    assign w_last_pix  = (r_ox == OUT_W - 1) && (r_oy == OUT_H - 1);
    assign w_last_filt = (r_f == 16'(NUM_FILT - 1));
    assign w_hs        = (r_state == S_WRITE) && bus.out_ready;

    assign w_iy       = $signed(r_oy * STRIDE + r_i) - PAD;
    assign w_ix       = $signed(r_ox * STRIDE + r_j) - PAD;
    assign w_in_range = (w_iy >= 0) && (w_iy < IMG_H) && (w_ix >= 0) && (w_ix < IMG_W);
    assign w_fm_lin   = r_c * (IMG_H * IMG_W) + $unsigned(w_iy) * IMG_W + $unsigned(w_ix);
    assign w_wt_lin   = {16'd0, r_f} * T + r_c * (KSIZE * KSIZE) + r_i * KSIZE + r_j;

    // Padding taps drive address 0 so the memory is never addressed outside the map.
    assign bus.fm_addr   = (r_state == S_FETCH && w_in_range) ? w_fm_lin : 32'd0;
    assign bus.wt_addr   = (r_state == S_FETCH) ? w_wt_lin : 32'd0;
    assign bus.par_addr  = r_f;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.out_valid = (r_state == S_WRITE);
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_word;

    logic signed [15:0] w_prod, w_bn_prod;
    logic signed [31:0] w_biased, w_shifted, w_bn_sum, w_bn, w_act_pre, w_lim, w_act_clamp;
    logic signed [7:0]  w_sat;
    logic [OUT_BITS-1:0] w_act;

    assign w_prod      = $signed(bus.fm_rdata) * $signed(bus.wt_rdata);
    assign w_biased    = r_acc + {{24{bus.bias_rdata[7]}}, bus.bias_rdata};
    assign w_shifted   = w_biased >>> ACC_SHIFT;
    assign w_sat       = (w_shifted > 127) ? 8'sh7F : (w_shifted < -128) ? 8'sh80 : w_shifted[7:0];
    assign w_bn_prod   = w_sat * $signed(bus.scale_rdata);
    assign w_bn_sum    = {{16{w_bn_prod[15]}}, w_bn_prod} + {{24{bus.shift_rdata[7]}}, bus.shift_rdata};
    assign w_bn        = w_bn_sum >>> BN_SHIFT;
    assign w_act_pre   = (w_bn + 32'sd128) >>> 5;
    assign w_lim       = r_relu6 ? 32'sd6 : 32'(ACT_MAX);
    assign w_act_clamp = (w_act_pre < 0) ? 32'sd0 : (w_act_pre > w_lim) ? w_lim : w_act_pre;
    assign w_act       = w_act_clamp[OUT_BITS-1:0];

    // Field gi of the word holds pixel gi of the group; the first pixel lands in the top bits.
    for (genvar gi = 0; gi < PACK; gi++) begin : g_pack
        assign w_word_next[32 - OUT_BITS * (gi + 1) +: OUT_BITS] =
            (r_slot == gi) ? r_act : r_word[32 - OUT_BITS * (gi + 1) +: OUT_BITS];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_FETCH;
            S_FETCH: if (w_last_tap) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_POST;
            S_POST:  w_state_next = S_PACK;
            S_PACK:  w_state_next = (r_slot == PACK - 1 || w_last_pix) ? S_WRITE : S_FETCH;
            S_WRITE: if (bus.out_ready) w_state_next = (r_plane_end && w_last_filt) ? S_DONE : S_FETCH;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_c <= '0; r_i <= '0; r_j <= '0; r_ox <= '0; r_oy <= '0; r_f <= '0;
            r_slot <= '0; r_out_addr <= '0; r_word <= '0; r_acc <= '0; r_act <= '0;
            r_relu6 <= 1'b0; r_plane_end <= 1'b0;
            r_acc_en <= 1'b0; r_oob_d <= 1'b0; r_first_d <= 1'b0;
        end else begin
            // Read data lags the issued tap by one cycle, so the tap's flags travel with it.
            r_acc_en  <= (r_state == S_FETCH);
            r_oob_d   <= !w_in_range;
            r_first_d <= (r_state == S_FETCH) && (r_c == 0) && (r_i == 0) && (r_j == 0);
            if (r_acc_en)
                r_acc <= (r_first_d ? 32'sd0 : r_acc) + (r_oob_d ? 32'sd0 : {{16{w_prod[15]}}, w_prod});
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_relu6 <= bus.cfg_relu6;
                    r_c <= '0; r_i <= '0; r_j <= '0; r_ox <= '0; r_oy <= '0; r_f <= '0;
                    r_slot <= '0; r_out_addr <= '0; r_word <= '0;
                end
                S_FETCH: begin
                    if (r_j == KSIZE - 1) begin
                        r_j <= '0;
                        if (r_i == KSIZE - 1) begin
                            r_i <= '0;
                            r_c <= (r_c == NUM_CH - 1) ? 32'd0 : r_c + 32'd1;
                        end else r_i <= r_i + 32'd1;
                    end else r_j <= r_j + 32'd1;
                end
                S_POST: r_act <= w_act;
                S_PACK: begin
                    r_word      <= w_word_next;
                    r_slot      <= r_slot + 32'd1;
                    r_plane_end <= w_last_pix;
                    if (r_ox == OUT_W - 1) begin
                        r_ox <= '0;
                        r_oy <= (r_oy == OUT_H - 1) ? 32'd0 : r_oy + 32'd1;
                    end else r_ox <= r_ox + 32'd1;
                end
                S_WRITE: if (w_hs) begin
                    r_word     <= '0;
                    r_slot     <= '0;
                    r_out_addr <= r_out_addr + 32'd1;
                    if (r_plane_end && !w_last_filt) r_f <= r_f + 16'd1;
                end
                S_DONE: r_f <= '0;
                default: ;
            endcase
        end
    end
endmodule
